// File: rtl/rft_engine_arbiter.sv
// rtl/rft_engine_arbiter.sv - round-robin scheduler sharing one RFT middleware engine
//
// Accepts 64-bit requests from NUM_REQ requesters, grants them round-robin, pulses
// eng_start once per grant, waits for a rising edge on eng_valid and returns the
// captured spectrum tagged with the winning requester's id.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   req_valid/req_data  : per-requester request (64 bits each, requester i at [64i+63:64i])
//   req_ready           : one-hot accept strobe, only ever high in IDLE
//   eng_start/eng_data  : engine start pulse and raw data input
//   eng_valid           : engine transform_valid (level; only its rising edge completes)
//   eng_amplitudes/eng_phases/eng_energy : engine results
//   rsp_valid/rsp_ready : response handshake
//   rsp_id/rsp_amplitudes/rsp_phases/rsp_energy/rsp_error : response payload
//   busy                : high whenever the scheduler is not idle
//
// Optional feature: define RFT_ARB_TIMEOUT_EN to give up on the engine after
// TIMEOUT_CYCLES WAIT cycles and return an error response with zeroed data.

module rft_engine_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [64*NUM_REQ-1:0]  req_data,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   eng_start,
  output logic [63:0]            eng_data,
  input  logic                   eng_valid,
  input  logic [127:0]           eng_amplitudes,
  input  logic [127:0]           eng_phases,
  input  logic [31:0]            eng_energy,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [2:0]             rsp_id,
  output logic [127:0]           rsp_amplitudes,
  output logic [127:0]           rsp_phases,
  output logic [31:0]            rsp_energy,
  output logic                   rsp_error,
  output logic                   busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t         state_q, state_d;
  logic [2:0]     rr_ptr_q, rr_ptr_d;
  logic [2:0]     id_q, id_d;
  logic [63:0]    data_q, data_d;
  logic [127:0]   amp_q, amp_d;
  logic [127:0]   ph_q, ph_d;
  logic [31:0]    energy_q, energy_d;
  logic           eng_valid_q;

  logic             gnt_found;
  logic [2:0]       gnt_idx;
  logic [2:0]       rr_next;
  logic [NUM_REQ-1:0] ready_c;

`ifdef RFT_ARB_TIMEOUT_EN
  logic [15:0]    cnt_q, cnt_d;
  logic           err_q, err_d;
`endif

  // First valid requester at or after rr_ptr, searching cyclically.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int idx;
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!gnt_found && req_valid[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = 3'(idx);
      end
    end
    rr_next = (int'(gnt_idx) == NUM_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    data_d   = data_q;
    amp_d    = amp_q;
    ph_d     = ph_q;
    energy_d = energy_q;
    ready_c  = '0;
`ifdef RFT_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          ready_c[gnt_idx] = 1'b1;
          data_d   = req_data[64*int'(gnt_idx) +: 64];
          id_d     = gnt_idx;
          rr_ptr_d = rr_next;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef RFT_ARB_TIMEOUT_EN
        cnt_d = 16'd0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A level already high when WAIT starts is a stale result; only an edge counts.
        if (eng_valid && !eng_valid_q) begin
          amp_d    = eng_amplitudes;
          ph_d     = eng_phases;
          energy_d = eng_energy;
`ifdef RFT_ARB_TIMEOUT_EN
          err_d    = 1'b0;
`endif
          state_d  = S_RESP;
        end
`ifdef RFT_ARB_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == 16'(TIMEOUT_CYCLES)) begin
            amp_d    = '0;
            ph_d     = '0;
            energy_d = '0;
            err_d    = 1'b1;
            state_d  = S_RESP;
          end
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      data_q      <= '0;
      amp_q       <= '0;
      ph_q        <= '0;
      energy_q    <= '0;
      eng_valid_q <= 1'b0;
`ifdef RFT_ARB_TIMEOUT_EN
      cnt_q       <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      data_q      <= data_d;
      amp_q       <= amp_d;
      ph_q        <= ph_d;
      energy_q    <= energy_d;
      eng_valid_q <= eng_valid;
`ifdef RFT_ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      err_q       <= err_d;
`endif
    end
  end

  // Grant strobe is suppressed while reset is held so no requester sees a false accept.
  assign req_ready      = reset ? '0 : ready_c;
  assign eng_start      = (state_q == S_ISSUE);
  assign eng_data       = data_q;
  assign rsp_valid      = (state_q == S_RESP);
  assign rsp_id         = id_q;
  assign rsp_amplitudes = amp_q;
  assign rsp_phases     = ph_q;
  assign rsp_energy     = energy_q;
  assign busy           = (state_q != S_IDLE);

`ifdef RFT_ARB_TIMEOUT_EN
  assign rsp_error = err_q;
`else
  // No timeout in this build: error is constant 0 and TIMEOUT_CYCLES has no effect.
  assign rsp_error = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_rft_engine_arbiter.sv
// tb/tb_rft_engine_arbiter.sv - self-checking bench for rft_engine_arbiter

module tb_rft_engine_arbiter;

  logic           clk = 1'b0;
  logic           reset;
  logic [3:0]     req_valid;
  logic [255:0]   req_data;
  logic [3:0]     req_ready;
  logic           eng_start;
  logic [63:0]    eng_data;
  logic           eng_valid;
  logic [127:0]   eng_amplitudes;
  logic [127:0]   eng_phases;
  logic [31:0]    eng_energy;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [2:0]     rsp_id;
  logic [127:0]   rsp_amplitudes;
  logic [127:0]   rsp_phases;
  logic [31:0]    rsp_energy;
  logic           rsp_error;
  logic           busy;

  int checks = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  rft_engine_arbiter #(.NUM_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .eng_start(eng_start), .eng_data(eng_data), .eng_valid(eng_valid),
    .eng_amplitudes(eng_amplitudes), .eng_phases(eng_phases), .eng_energy(eng_energy),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_amplitudes(rsp_amplitudes), .rsp_phases(rsp_phases), .rsp_energy(rsp_energy),
    .rsp_error(rsp_error), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [2:0] exp_id;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] req_word(input int i);
    return {32'hD00D_0000 + 32'(i), 32'h1234_5670 + 32'(i)};
  endfunction

  task automatic set_engine(input int seed);
    eng_amplitudes = {8{16'h1000 + 16'(seed)}};
    eng_phases     = {8{16'h8000 + 16'(seed)}};
    eng_energy     = 32'hE000_0000 + 32'(seed);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    eng_valid = 1'b0;
    rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_id"}, rsp_id, 0);
    chk({tag, "_rsp_err"}, rsp_error, 0);
    chk({tag, "_rsp_energy"}, rsp_energy, 0);
    chk({tag, "_rsp_amp"}, rsp_amplitudes, 0);
    chk({tag, "_rsp_ph"}, rsp_phases, 0);
    chk({tag, "_eng_start"}, eng_start, 0);
    chk({tag, "_eng_data"}, eng_data, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req_ready"}, req_ready, 0);
  endtask

  // req_ready must never be seen outside IDLE.
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if (busy !== 1'b0 && req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL ready_outside_idle actual=%b required=0000", req_ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int starts;
    logic [31:0] held_energy;

    vecs[0]  = '{4'b1111, 4'b0001, 3'd0};
    vecs[1]  = '{4'b1111, 4'b0010, 3'd1};
    vecs[2]  = '{4'b1111, 4'b0100, 3'd2};
    vecs[3]  = '{4'b1111, 4'b1000, 3'd3};
    vecs[4]  = '{4'b1111, 4'b0001, 3'd0};
    vecs[5]  = '{4'b0001, 4'b0001, 3'd0};
    vecs[6]  = '{4'b1000, 4'b1000, 3'd3};
    vecs[7]  = '{4'b0110, 4'b0010, 3'd1};
    vecs[8]  = '{4'b0110, 4'b0100, 3'd2};
    vecs[9]  = '{4'b0011, 4'b0001, 3'd0};
    vecs[10] = '{4'b0100, 4'b0100, 3'd2};

    for (int i = 0; i < 4; i++) req_data[64*i +: 64] = req_word(i);
    set_engine(0);
    do_reset();
    mon_en = 1'b1;
    #1;
    chk_idle_zero("reset");

    // Round-robin table, rsp_ready held high throughout.
    rsp_ready = 1'b1;
    for (int v = 0; v < 11; v++) begin
      req_valid = vecs[v].valid;
      #1;
      chk("rr_ready", req_ready, vecs[v].exp_ready);
      tick();
      chk("rr_start", eng_start, 1);
      chk("rr_eng_data", eng_data, req_word(int'(vecs[v].exp_id)));
      tick();
      set_engine(v + 1);
      eng_valid = 1'b1;
      tick();
      chk("rr_rsp_valid", rsp_valid, 1);
      chk("rr_rsp_id", rsp_id, vecs[v].exp_id);
      chk("rr_rsp_energy", rsp_energy, 32'hE000_0000 + 32'(v + 1));
      chk("rr_rsp_amp", rsp_amplitudes, {8{16'h1000 + 16'(v + 1)}});
      eng_valid = 1'b0;
      tick();
      chk("rr_back_idle", busy, 0);
    end
    req_valid = '0;
    rsp_ready = 1'b0;

    // Single request from requester 2; engine answers 12 cycles after start.
    do_reset();
    req_data[128 +: 64] = 64'h1;
    req_valid = 4'b0100;
    #1;
    chk("single_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    starts = int'(eng_start);
    chk("single_eng_data", eng_data, 64'h1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      starts += int'(eng_start);
      if (k < 12) chk("single_no_rsp_early", rsp_valid, 0);
    end
    set_engine(77);
    eng_valid = 1'b1;
    tick();
    starts += int'(eng_start);
    chk("single_rsp_valid", rsp_valid, 1);
    chk("single_rsp_id", rsp_id, 2);
    chk("single_amp", rsp_amplitudes, {8{16'h1000 + 16'd77}});
    chk("single_ph", rsp_phases, {8{16'h8000 + 16'd77}});
    chk("single_energy", rsp_energy, 32'hE000_0000 + 32'd77);
    chk("single_err", rsp_error, 0);
    chk("single_start_count", starts, 1);
    chk("single_eng_data_held", eng_data, 64'h1);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("single_idle", busy, 0);
    req_data[128 +: 64] = req_word(2);

    // Engine valid stuck high from the previous job: no completion until it re-rises.
    // rr_ptr is now 3; only requester 1 asks.
    req_valid = 4'b0010;
    #1;
    chk("stuck_ready", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stuck_no_rsp", rsp_valid, 0);
    end
    eng_valid = 1'b0;
    tick();
    chk("stuck_low_no_rsp", rsp_valid, 0);
    set_engine(200);
    eng_valid = 1'b1;
    tick();
    chk("stuck_rsp_valid", rsp_valid, 1);
    chk("stuck_rsp_id", rsp_id, 1);
    chk("stuck_energy", rsp_energy, 32'hE000_0000 + 32'd200);

    // Response back-pressure for 5 cycles with another request and engine noise.
    held_energy = 32'hE000_0000 + 32'd200;
    req_valid = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      eng_valid = ~eng_valid;
      set_engine(300 + k);
      tick();
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rsp_id", rsp_id, 1);
      chk("hold_energy", rsp_energy, held_energy);
      chk("hold_amp", rsp_amplitudes, {8{16'h1000 + 16'd200}});
      chk("hold_ready_low", req_ready, 0);
    end
    eng_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hold_released_ready", req_ready, 4'b1000);

    // Reset mid-WAIT, then a late engine edge must be ignored.
    tick();
    chk("rst_issue_data", eng_data, req_word(3));
    req_valid = '0;
    tick();
    chk("rst_in_wait", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_idle_zero("rst");
    tick();
    tick();
    set_engine(400);
    eng_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rst_late_no_rsp", rsp_valid, 0);
      chk("rst_late_idle", busy, 0);
    end
    chk("rst_late_energy", rsp_energy, 0);
    eng_valid = 1'b0;

`ifdef RFT_ARB_TIMEOUT_EN
    // Engine never answers: error response after 16 WAIT cycles.
    do_reset();
    set_engine(500);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    begin
      int n;
      n = 0;
      while (rsp_valid !== 1'b1 && n < 40) begin
        tick();
        n++;
      end
      chk("to_latency", n, 17);
    end
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_err", rsp_error, 1);
    chk("to_energy", rsp_energy, 0);
    chk("to_amp", rsp_amplitudes, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;

    // Valid edge in the very cycle the count reaches the limit wins.
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    for (int k = 0; k < 16; k++) tick();
    chk("race_still_wait", rsp_valid, 0);
    set_engine(600);
    eng_valid = 1'b1;
    tick();
    chk("race_rsp_valid", rsp_valid, 1);
    chk("race_err", rsp_error, 0);
    chk("race_energy", rsp_energy, 32'hE000_0000 + 32'd600);
    eng_valid = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
